reg_encoder: RTL and testbench

Transmit end of the chiptune register-write link. Accepts register-write commands (address 0..3 for reg_4000..reg_4003, plus 8-bit data) from a local host/sequencer. Serialises each command onto the sck/sdi pair consumed by the chiptune decoder. Provides a one-deep command buffer, so a new write can be queued while the current frame is on the wire.

---
 rtl/chiptune_pkg.sv | 31 +++
 rtl/baud_gen.sv | 37 +++
 rtl/reg_encoder.sv | 133 +++++++++++++
 tb/tb_reg_encoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chiptune_pkg.sv
// Shared definitions for the chiptune register-write link: frame constants,
// register selects, transmitter states and the queued command payload.
package chiptune_pkg;

    localparam logic [3:0]  HDR_MARK      = 4'hA;
    localparam int unsigned FRAME_BITS    = 10;
    localparam int unsigned BYTES_PER_CMD = 2;

    localparam logic [1:0] REG_4000 = 2'd0;
    localparam logic [1:0] REG_4001 = 2'd1;
    localparam logic [1:0] REG_4002 = 2'd2;
    localparam logic [1:0] REG_4003 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_cmd_t;

    // Header byte identifying the target register of a command.
    function automatic logic [7:0] header_byte(input logic [1:0] addr);
        return {HDR_MARK, 2'b00, addr};
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running bit-clock divider: sck is low for the first half of each
// bit period and bit_tick marks the last clk of the period.
module baud_gen #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic sck,
    output logic bit_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt + CW'(1);
        if (div_cnt == CW'(DIV - 1)) begin
            div_cnt_d = '0;
        end
    end

    // sck and bit_tick are registered from the next count so they align with div_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            sck      <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            div_cnt  <= div_cnt_d;
            sck      <= (div_cnt_d >= CW'(DIV / 2));
            bit_tick <= (div_cnt_d == CW'(DIV - 1));
        end
    end

endmodule

// File: rtl/reg_encoder.sv
// Transmit end of the chiptune register-write link: one-deep command buffer
// feeding a serialiser that sends header + data bytes as back-to-back 8N1.
module reg_encoder
    import chiptune_pkg::*;
#(
    parameter int unsigned CLKRATE = 4800,
    parameter int unsigned BAUD    = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       sck,
    output logic       sdi,
    output logic       busy
);

    localparam int unsigned DIV       = CLKRATE / BAUD;
    localparam int unsigned DATA_BITS = FRAME_BITS - 2;

    logic       bit_tick;
    tx_state_t  state, state_d;
    wr_cmd_t    pend, pend_d;
    logic       buf_full, buf_full_d;
    logic [7:0] shift, shift_d;
    logic [7:0] cur_data, cur_data_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic       byte_sel, byte_sel_d;
    logic       sdi_d;
    logic       load_cmd;
    logic       accept;

    baud_gen #(.DIV(DIV)) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck      (sck),
        .bit_tick (bit_tick)
    );

    assign accept = wr_valid & wr_ready;

    // Bit sequencing happens only on bit_tick, so sdi moves only as sck falls.
    always_comb begin
        state_d    = state;
        pend_d     = pend;
        buf_full_d = buf_full;
        shift_d    = shift;
        cur_data_d = cur_data;
        bit_idx_d  = bit_idx;
        byte_sel_d = byte_sel;
        sdi_d      = sdi;
        load_cmd   = 1'b0;

        if (bit_tick) begin
            case (state)
                IDLE: load_cmd = buf_full;
                START: begin
                    state_d = DATA;
                    sdi_d   = shift[0];
                end
                DATA: begin
                    shift_d   = shift >> 1;
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        sdi_d   = 1'b1;
                    end else begin
                        sdi_d = shift[1];
                    end
                end
                STOP: begin
                    if (byte_sel != 1'(BYTES_PER_CMD - 1)) begin
                        shift_d    = cur_data;
                        byte_sel_d = 1'b1;
                        state_d    = START;
                        sdi_d      = 1'b0;
                    end else if (buf_full) begin
                        load_cmd = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sdi_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load_cmd) begin
            shift_d    = header_byte(pend.addr);
            cur_data_d = pend.data;
            byte_sel_d = 1'b0;
            state_d    = START;
            sdi_d      = 1'b0;
            buf_full_d = 1'b0;
        end

        // A same-cycle accept wins, leaving the buffer full with the new command.
        if (accept) begin
            buf_full_d  = 1'b1;
            pend_d.addr = wr_addr;
            pend_d.data = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            buf_full <= 1'b0;
            shift    <= '0;
            cur_data <= '0;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
            sdi      <= 1'b1;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            pend     <= pend_d;
            buf_full <= buf_full_d;
            shift    <= shift_d;
            cur_data <= cur_data_d;
            bit_idx  <= bit_idx_d;
            byte_sel <= byte_sel_d;
            sdi      <= sdi_d;
            wr_ready <= !buf_full_d;
            busy     <= (state_d != IDLE) | buf_full_d;
        end
    end

endmodule

// File: tb/tb_reg_encoder.sv
// Self-checking bench for reg_encoder: a behavioural UART receiver decodes
// the sdi line and compares every byte against the commands written.
module tb_reg_encoder;
    import chiptune_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, wr_ready, sck, sdi, busy;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       v1, rdy1, sck1, sdi1, busy1;
    logic [1:0] a1;
    logic [7:0] d1;

    int errors = 0;
    int checks = 0;
    int frames = 0;
    logic [7:0] exp_q[$];
    int         gap_q[$];

    reg_encoder dut0 (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .sck(sck), .sdi(sdi), .busy(busy)
    );

    reg_encoder #(.CLKRATE(9600), .BAUD(300)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_valid(v1), .wr_ready(rdy1),
        .wr_addr(a1), .wr_data(d1), .sck(sck1), .sdi(sdi1), .busy(busy1)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line bits in time order, index 0 = header start bit.
    function automatic logic [19:0] frame_bits(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] h;
        h = {4'hA, 2'b00, a};
        return {1'b1, d, 1'b0, 1'b1, h, 1'b0};
    endfunction

    // Receiver model: sample sdi at each sck rise, decode 8N1 frames.
    logic       mon_sck_p = 1'b0;
    int         rx_cnt = 0;
    int         idle_bits = 0;
    logic [9:0] rx_bits = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_cnt    = 0;
            idle_bits = 0;
        end else if (sck && !mon_sck_p) begin
            if (rx_cnt == 0) begin
                if (sdi === 1'b0) begin
                    rx_bits[0] = 1'b0;
                    rx_cnt     = 1;
                    gap_q.push_back(idle_bits);
                    idle_bits  = 0;
                end else begin
                    idle_bits++;
                end
            end else begin
                rx_bits[rx_cnt] = sdi;
                rx_cnt++;
                if (rx_cnt == 10) begin
                    logic [7:0] e;
                    rx_cnt = 0;
                    frames++;
                    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_byte", 32'(rx_bits[8:1]), 32'(e));
                        check("stop_bit", 32'(rx_bits[9]), 32'd1);
                    end
                end
            end
        end
        mon_sck_p = sck;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d, output int waited);
        waited   = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (wr_ready !== 1'b1 && waited < 1000) begin
            tick();
            waited++;
        end
        check("accept_timeout", 32'(waited < 1000), 32'd1);
        if (waited < 1000) begin
            tick();
            exp_q.push_back({4'hA, 2'b00, a});
            exp_q.push_back(d);
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 1000), 32'd1);
    endtask

    task automatic sck_period(input bit sel, output int per);
        logic p, cur;
        int   n;
        n = 0;
        p = sel ? sck1 : sck;
        while (n < 200) begin
            tick();
            n++;
            cur = sel ? sck1 : sck;
            if (cur && !p) break;
            p = cur;
        end
        per = 0;
        p   = 1'b1;
        while (per < 200) begin
            tick();
            per++;
            cur = sel ? sck1 : sck;
            if (cur && !p) break;
            p = cur;
        end
    endtask

    initial begin
        int w, n, per, low, f0, g0, bad, trans, k;
        logic [19:0] got;
        logic sp, dp;

        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        v1 = 1'b0; a1 = '0; d1 = '0;
        repeat (3) tick();
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_sdi", 32'(sdi), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Idle line and bit clock
        sck_period(1'b0, per);
        check("sck_period_16", 32'(per), 32'd16);
        sck_period(1'b1, per);
        check("sck_period_32", 32'(per), 32'd32);
        low = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sdi !== 1'b1 || busy !== 1'b0) low++;
        end
        check("idle_sdi_high", 32'(low), 32'd0);

        // Single write: latency and frame duration
        f0 = frames;
        do_write(REG_4002, 8'h3C, w);
        n = 0;
        while (sdi !== 1'b0 && n < 100) begin tick(); n++; end
        check("first_start_latency", 32'(n >= 1 && n <= 16), 32'd1);
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin tick(); n++; end
        check("busy_duration", 32'(n), 32'd320);
        repeat (20) tick();
        check("single_frames", 32'(frames - f0), 32'd2);

        // Back-to-back commands
        g0 = gap_q.size();
        do_write(REG_4000, 8'h8F, w);
        do_write(REG_4003, 8'h01, w);
        check("ready_low_after_2nd", 32'(wr_ready), 32'd0);
        n = 0; low = 0;
        while (wr_ready !== 1'b1 && n < 1000) begin
            tick(); n++;
            if (busy !== 1'b1) low++;
        end
        check("ready_hold_cycles", 32'(n), 32'd319);
        check("busy_during_b2b", 32'(low), 32'd0);
        check("hdr2_start_at_ready", 32'(sdi), 32'd0);
        wait_idle("b2b_idle");
        repeat (20) tick();
        check("b2b_gap_count", 32'(gap_q.size() >= g0 + 4), 32'd1);
        if (gap_q.size() >= g0 + 4)
            check("b2b_gaps", 32'(gap_q[g0+1] + gap_q[g0+2] + gap_q[g0+3]), 32'd0);

        // Back-pressure with a full buffer; data changes after accept
        do_write(REG_4001, 8'h11, w);
        n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin tick(); n++; end
        do_write(REG_4002, 8'h22, w);
        do_write(REG_4001, 8'h55, w);
        wr_data = 8'hAA;
        wr_addr = REG_4003;
        check("backpressure_held", 32'(w > 16), 32'd1);
        check("ready_low_after_bp", 32'(wr_ready), 32'd0);
        wait_idle("bp_idle");
        repeat (20) tick();

        // Randomized commands with random spacing
        for (int i = 0; i < 10; i++) begin
            do_write(2'($urandom_range(0, 3)), 8'($urandom), w);
            repeat ($urandom_range(0, 400)) tick();
        end
        wait_idle("rand_idle");
        repeat (20) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset during header data bits
        do_write(REG_4003, 8'hC3, w);
        n = 0;
        while (sdi !== 1'b0 && n < 100) begin tick(); n++; end
        do_write(REG_4000, 8'h44, w);
        repeat (40) tick();
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_sdi", 32'(sdi), 32'd1);
        check("mid_rst_sck", 32'(sck), 32'd0);
        check("mid_rst_ready", 32'(wr_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sdi !== 1'b1 || busy !== 1'b0) low++;
        end
        check("no_resume_after_rst", 32'(low), 32'd0);
        f0 = frames;
        do_write(REG_4001, 8'hFF, w);
        wait_idle("post_rst_idle");
        repeat (20) tick();
        check("post_rst_frames", 32'(frames - f0), 32'd2);

        // DIV=32 instance: exact bit pattern and edge alignment
        v1 = 1'b1; a1 = REG_4002; d1 = 8'h5A;
        n = 0;
        while (rdy1 !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        v1 = 1'b0; d1 = 8'h00;
        got = '0; k = 0; n = 0; bad = 0; trans = 0;
        sp = sck1; dp = sdi1;
        while (k < 20 && n < 3000) begin
            tick(); n++;
            if (sdi1 !== dp) begin
                trans++;
                if (!(sp === 1'b1 && sck1 === 1'b0)) bad++;
            end
            if (sck1 && !sp && (k > 0 || sdi1 === 1'b0)) begin
                got[k] = sdi1;
                k++;
            end
            sp = sck1; dp = sdi1;
        end
        check("div32_bits", 32'(got), 32'(frame_bits(REG_4002, 8'h5A)));
        check("div32_edge_align", 32'(bad), 32'd0);
        check("div32_transitions", 32'(trans > 0), 32'd1);
        n = 0;
        while (busy1 !== 1'b0 && n < 200) begin tick(); n++; end
        check("div32_idle", 32'(n < 200), 32'd1);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
